// File: rtl/writeback_register_file.sv
// Writeback stage: selects memory/ALU data, commits it to the register file and counts retired writes.
// Define WB_WRITE_BYPASS_EN to forward same-cycle writeback data onto the ID read ports A/B.
module writeback_register_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_shouldWriteRegister,
  input  logic [ADDR_WIDTH-1:0]  wb_registerWriteAddress,
  input  logic                   wb_shouldWriteMemoryElseAluOutputToRegister,
  input  logic [DATA_WIDTH-1:0]  wb_memoryData,
  input  logic [DATA_WIDTH-1:0]  wb_aluOutput,
  input  logic [ADDR_WIDTH-1:0]  id_readAddressA,
  input  logic [ADDR_WIDTH-1:0]  id_readAddressB,
  input  logic [ADDR_WIDTH-1:0]  debug_readAddress,
  output logic [DATA_WIDTH-1:0]  id_readDataA,
  output logic [DATA_WIDTH-1:0]  id_readDataB,
  output logic [DATA_WIDTH-1:0]  debug_readData,
  output logic [DATA_WIDTH-1:0]  wb_writeData,
  output logic [COUNT_WIDTH-1:0] wb_retiredWriteCount
);

  localparam int NumRegisters = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  registers [NumRegisters];
  logic [COUNT_WIDTH-1:0] retiredWriteCount;
  logic                   commit;
  logic [DATA_WIDTH-1:0]  storedA;
  logic [DATA_WIDTH-1:0]  storedB;

  assign wb_writeData = wb_shouldWriteMemoryElseAluOutputToRegister ? wb_memoryData : wb_aluOutput;

  // Register 0 is hardwired: writes to it never commit and never count.
  assign commit = reset && wb_shouldWriteRegister && (wb_registerWriteAddress != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NumRegisters; i++) begin
        registers[i] <= '0;
      end
      retiredWriteCount <= '0;
    end else if (commit) begin
      registers[wb_registerWriteAddress] <= wb_writeData;
      retiredWriteCount                  <= retiredWriteCount + COUNT_WIDTH'(1);
    end
  end

  assign wb_retiredWriteCount = retiredWriteCount;

  // Address 0 is decoded to zero explicitly so it reads 0 regardless of array contents.
  assign storedA        = (id_readAddressA   == '0) ? '0 : registers[id_readAddressA];
  assign storedB        = (id_readAddressB   == '0) ? '0 : registers[id_readAddressB];
  assign debug_readData = (debug_readAddress == '0) ? '0 : registers[debug_readAddress];

`ifdef WB_WRITE_BYPASS_EN
  // commit already excludes reset cycles and address 0, so bypass inherits both suppressions.
  assign id_readDataA = (commit && (id_readAddressA == wb_registerWriteAddress)) ? wb_writeData : storedA;
  assign id_readDataB = (commit && (id_readAddressB == wb_registerWriteAddress)) ? wb_writeData : storedB;
`else
  assign id_readDataA = storedA;
  assign id_readDataB = storedB;
`endif

endmodule
